// File: rtl/bsg_dff_rr_share_pkg.sv
// bsg_dff_rr_share_pkg: shared sizing helper for the round-robin shared register.
package bsg_dff_rr_share_pkg;

    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/bsg_rr_grant.sv
// bsg_rr_grant: combinational round-robin grant, searching upward from the slot after last.
module bsg_rr_grant #(
    parameter int els_p = 4,
    parameter int lg_els_lp = 2
) (
    input  logic [els_p-1:0]     req,
    input  logic [lg_els_lp-1:0] last,
    input  logic                 en,
    output logic [els_p-1:0]     grant,
    output logic [lg_els_lp-1:0] grant_id
);

    int  idx;
    logic found;

    always_comb begin
        grant = '0;
        grant_id = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 1; k <= els_p; k++) begin
            idx = (int'(last) + k) % els_p;
            if (en && !found && req[idx]) begin
                found = 1'b1;
                grant[idx] = 1'b1;
                grant_id = lg_els_lp'(idx);
            end
        end
    end

endmodule

// File: rtl/bsg_dff_rr_share.sv
// bsg_dff_rr_share: one holding register shared by els_p requesters via round-robin arbitration,
// producing a tagged stream (payload plus requester index) at up to one word per cycle.
module bsg_dff_rr_share
    import bsg_dff_rr_share_pkg::*;
#(
    parameter int els_p = 4,
    parameter int width_p = 16,
    localparam int lg_els_lp = safe_clog2(els_p)
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic [els_p-1:0]           v_i,
    input  logic [els_p*width_p-1:0]   data_i,
    output logic [els_p-1:0]           ready_o,
    output logic                       v_o,
    output logic [width_p-1:0]         data_o,
    output logic [lg_els_lp-1:0]       id_o,
    input  logic                       yumi_i
);

    logic                 v_r;
    logic [width_p-1:0]   data_r;
    logic [lg_els_lp-1:0] id_r, last_r, grant_id;
    logic [width_p-1:0]   words [els_p];
    logic                 open, accept;

    for (genvar i = 0; i < els_p; i++) begin : g_words
        assign words[i] = data_i[i*width_p +: width_p];
    end

    // open includes yumi_i so a drain and a refill can share a cycle
    assign open = ~v_r | yumi_i;

    bsg_rr_grant #(.els_p(els_p), .lg_els_lp(lg_els_lp)) arb (
        .req(v_i),
        .last(last_r),
        .en(open & ~reset_i),
        .grant(ready_o),
        .grant_id(grant_id)
    );

    assign accept = |ready_o;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            v_r <= 1'b0;
            data_r <= '0;
            id_r <= '0;
            last_r <= lg_els_lp'(els_p - 1);
        end else if (accept) begin
            v_r <= 1'b1;
            data_r <= words[grant_id];
            id_r <= grant_id;
            last_r <= grant_id;
        end else if (yumi_i) begin
            v_r <= 1'b0;
        end
    end

    assign v_o = v_r;
    assign data_o = data_r;
    assign id_o = id_r;

    assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_r)
        else $error("yumi_i asserted while holding register empty");

endmodule
